// File: rtl/spike_ctrl.sv
// spike_ctrl: trains an adaptive spike threshold, then qualifies, counts and timestamps detector spikes.
// Optional SPIKE_CTRL_MANUAL_THR_EN adds manual_en/manual_thr to bypass training.
module spike_ctrl #(
  parameter int LOG2_TRAIN    = 4,
  parameter int GAIN_SHIFT    = 2,
  parameter int REFRAC_CYCLES = 8,
  parameter int THR_MIN       = 16,
  parameter int THR_DEFAULT   = 10000
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SPIKE_CTRL_MANUAL_THR_EN
  input  logic        manual_en,
  input  logic [15:0] manual_thr,
`endif
  input  logic        start,
  input  logic        stop,
  input  logic        sample_valid,
  input  logic [15:0] data_in,
  input  logic        spike_in,
  input  logic        evt_ready,
  output logic [15:0] threshold_out,
  output logic        det_en,
  output logic        busy,
  output logic        evt_valid,
  output logic [15:0] evt_time,
  output logic [15:0] spike_count,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, TRAIN, CALC, RUN} state_t;
  localparam int AW = 16 + LOG2_TRAIN;

  state_t                state_q, state_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [LOG2_TRAIN-1:0] cnt_q, cnt_d;
  logic [15:0]           thr_q, thr_d;
  logic [15:0]           ts_q, ts_d;
  logic [7:0]            refrac_q, refrac_d;
  logic                  evt_valid_q, evt_valid_d;
  logic [15:0]           evt_time_q, evt_time_d;
  logic [15:0]           spike_count_q, spike_count_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           mag, mean, thr_calc;
  logic [35:0]           t;
  logic                  qual;

  always_comb begin
    mag = data_in[15] ? 16'(16'd0 - data_in) : data_in;
    mean = acc_q[AW-1:LOG2_TRAIN];
    t = (36'(mean) * 36'(mean)) << GAIN_SHIFT;
    thr_calc = t > 36'd32767 ? 16'd32767 : t < 36'(THR_MIN) ? 16'(THR_MIN) : t[15:0];
    qual = state_q == RUN && spike_in && refrac_q == 8'd0;
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    thr_d = thr_q;
    ts_d = ts_q;
    refrac_d = refrac_q;
    evt_valid_d = evt_valid_q && !evt_ready;
    evt_time_d = evt_time_q;
    spike_count_d = spike_count_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = TRAIN;
        acc_d = '0;
        cnt_d = '0;
        spike_count_d = '0;
        overrun_d = 1'b0;
        ts_d = '0;
`ifdef SPIKE_CTRL_MANUAL_THR_EN
        if (manual_en) begin
          state_d = RUN;
          thr_d = manual_thr[15] ? 16'd0 : manual_thr;
        end
`endif
      end
      TRAIN: if (sample_valid) begin
        acc_d = acc_q + AW'(mag);
        cnt_d = cnt_q + LOG2_TRAIN'(1);
        state_d = &cnt_q ? CALC : TRAIN;
      end
      CALC: begin
        thr_d = thr_calc;
        state_d = RUN;
      end
      default: begin
        ts_d = ts_q + 16'd1;
        refrac_d = refrac_q != 8'd0 ? refrac_q - 8'd1 : 8'd0;
      end
    endcase
    // a free slot exists if nothing is pending or the pending event leaves this cycle
    if (qual) begin
      refrac_d = 8'(REFRAC_CYCLES);
      spike_count_d = &spike_count_q ? spike_count_q : spike_count_q + 16'd1;
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_time_d = ts_q;
      end else
        overrun_d = 1'b1;
    end
    if (state_q == RUN && stop) begin
      state_d = IDLE;
      refrac_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      thr_q <= 16'(THR_DEFAULT);
      ts_q <= '0;
      refrac_q <= '0;
      evt_valid_q <= 1'b0;
      evt_time_q <= '0;
      spike_count_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      thr_q <= thr_d;
      ts_q <= ts_d;
      refrac_q <= refrac_d;
      evt_valid_q <= evt_valid_d;
      evt_time_q <= evt_time_d;
      spike_count_q <= spike_count_d;
      overrun_q <= overrun_d;
    end
  end

  assign threshold_out = thr_q;
  assign det_en = state_q == RUN;
  assign busy = state_q != IDLE;
  assign evt_valid = evt_valid_q;
  assign evt_time = evt_time_q;
  assign spike_count = spike_count_q;
  assign overrun = overrun_q;
endmodule

// File: doc/spike_ctrl.md
# spike_ctrl

Sequencing controller for the spike-detector datapath. After `start` it collects a training window of samples and derives an adaptive 16-bit threshold from their mean absolute amplitude. It then drives that threshold and an enable into the detector. In operation it qualifies the detector's `spike_detected` pulses with a refractory window, counts them, and presents each accepted spike as a timestamped event on a valid/ready port.

## Interface
Parameters:
- `LOG2_TRAIN`, default 4: training window is 2^LOG2_TRAIN valid samples (legal 1..8).
- `GAIN_SHIFT`, default 2: left shift applied to mean² (legal 0..4).
- `REFRAC_CYCLES`, default 8: number of cycles spikes are ignored after an accepted spike (1..255).
- `THR_MIN`, default 16: threshold floor.
- `THR_DEFAULT`, default 10000: threshold value out of reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: clock.
- `rst` input 1: asynchronous active-high reset.
- `start` input 1: begin training (honoured in IDLE only).
- `stop` input 1: return to IDLE (honoured in RUN only).
- `sample_valid` input 1: `data_in` carries a valid sample.
- `data_in` input 16: signed sample.
- `spike_in` input 1: detector `spike_detected`.
- `evt_ready` input 1: event consumer ready.
- `threshold_out` output 16: signed threshold to the detector; always ≥ 0.
- `det_en` output 1: detector enable.
- `busy` output 1: state ≠ IDLE.
- `evt_valid` output 1: event pending.
- `evt_time` output 16: timestamp of the pending event.
- `spike_count` output 16: count of qualified spikes; saturates at 0xFFFF.
- `overrun` output 1: sticky flag, set when an event is dropped.

## Operation
- **States:** IDLE → TRAIN → CALC → RUN → IDLE.
- **IDLE:**
  - `start` = 1 → TRAIN.
  - On entry to TRAIN: clear the accumulator, sample counter, `spike_count`, `overrun` and the timestamp.
- **TRAIN:**
  - On each `sample_valid`, add |`data_in`| (16-bit unsigned; |−32768| = 32768) to a (16+LOG2_TRAIN)-bit accumulator.
  - On the 2^LOG2_TRAIN-th valid sample → CALC.
  - `start` and `stop` are ignored.
- **CALC (exactly 1 cycle):**
  - mean = acc >> LOG2_TRAIN, 16-bit unsigned.
  - t = (mean × mean) << GAIN_SHIFT, computed at 36-bit unsigned width.
  - `threshold_out` = 32767 if t > 32767; THR_MIN if t < THR_MIN; t otherwise.
  - → RUN.
- **RUN:**
  - `det_en` = 1.
  - The 16-bit timestamp increments every cycle and wraps at 0xFFFF → 0.
  - A spike is qualified when `spike_in` = 1 and the refractory counter = 0.
  - On a qualified spike:
    - load the refractory counter with REFRAC_CYCLES; it decrements each cycle to 0;
    - increment `spike_count`;
    - if no event is pending, or the pending event is accepted this same cycle, capture the timestamp into `evt_time` and set `evt_valid`;
    - otherwise drop the spike and set `overrun`.
  - `stop` → IDLE. The refractory counter clears; `threshold_out` holds; a pending event stays until accepted.
- **Handshake:**
  - Transfer occurs on `evt_valid` && `evt_ready`.
  - `evt_valid` and `evt_time` are stable until the transfer.
  - Acceptance and a new capture in the same cycle leave `evt_valid` = 1 with the new `evt_time`.
- **Reset (any state, including mid-TRAIN):**
  - state = IDLE, `threshold_out` = THR_DEFAULT, `det_en` = 0, `busy` = 0, `evt_valid` = 0, `evt_time` = 0, `spike_count` = 0, `overrun` = 0.
  - Accumulator and all counters = 0.

## Timing
- `start` sampled in cycle n → `busy` = 1 in n+1.
- Last training sample in cycle m → CALC in m+1 → `threshold_out` updated and `det_en` = 1 from m+2.
- Qualified `spike_in` in cycle n → `evt_valid` and `spike_count` updated in n+1.
- `evt_time` equals the timestamp value in cycle n.
- The next spike can qualify no earlier than cycle n+REFRAC_CYCLES+1.
- `stop` in cycle n → `det_en` = 0 in n+1.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- **`SPIKE_CTRL_MANUAL_THR_EN` defined:**
  - Adds input `manual_en` (1 bit) and input `manual_thr` (16 bits).
  - `start` with `manual_en` = 1 goes IDLE → RUN directly, skipping TRAIN and CALC.
  - `threshold_out` = `manual_thr` clamped to [0, 32767]; negative values give 0.
  - `det_en` = 1 from the next cycle.
  - `start` with `manual_en` = 0 trains as normal.
- **Not defined:** no such ports; every `start` trains.

## Test plan
Parameters for all scenarios: LOG2_TRAIN = 4, GAIN_SHIFT = 2, REFRAC_CYCLES = 8, THR_MIN = 16.
1. 16 valid samples alternating +20/−20 → `threshold_out` = 1600, `det_en` rises 2 cycles after the 16th sample.
2. Samples ±200 → `threshold_out` = 32767 (saturation); all-zero samples → 16 (floor); one sample −32768 plus 15 zeros → mean 2048 → 32767.
3. RUN with `spike_in` held at 1 and `evt_ready` = 1 for 30 cycles → events every 9 cycles, `spike_count` = 4, `evt_time` deltas = 9.
4. `evt_ready` = 0, `spike_in` pulses 9 cycles apart → first event held, second dropped, `overrun` = 1, `spike_count` = 2; raising `evt_ready` returns the first `evt_time`.
5. `rst` asserted after 7 training samples → all outputs at reset values, `threshold_out` = 10000; a new `start` needs a full 16 samples.
6. With `SPIKE_CTRL_MANUAL_THR_EN`, `manual_en` = 1, `manual_thr` = −5 → RUN next cycle, `threshold_out` = 0; `manual_thr` = 1234 → 1234.
